// File: rtl/network_sink.sv
// Packs accepted spike vectors into SPK words and zero-vector runs into RUN words,
// queued through a 4-entry registered output FIFO.
package network_config;
  localparam int unsigned NET_NUM_OUT = 4;
endpackage

package sink_config;
  import network_config::*;

  typedef enum logic [0:0] {SPK = 1'b0, RUN = 1'b1} opcode_t;

  localparam int unsigned SNK_OPC_WIDTH = 1;

  function automatic int unsigned snk_pay_width(input int unsigned run_w);
    return (NET_NUM_OUT > run_w) ? NET_NUM_OUT : run_w;
  endfunction

  function automatic int unsigned snk_width(input int unsigned run_w);
    return SNK_OPC_WIDTH + snk_pay_width(run_w);
  endfunction
endpackage

module network_sink
  import network_config::*;
  import sink_config::*;
#(
  parameter int unsigned SNK_RUN_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                arstn,
  input  logic                                net_valid,
  output logic                                net_ready,
  input  logic                                net_out [0:NET_NUM_OUT-1],
  input  logic                                flush,
  output logic                                snk_valid,
  input  logic                                snk_ready,
  output logic [snk_width(SNK_RUN_WIDTH)-1:0] snk
);

  localparam int unsigned PAY_W = snk_pay_width(SNK_RUN_WIDTH);
  localparam int unsigned W     = SNK_OPC_WIDTH + PAY_W;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam logic [SNK_RUN_WIDTH-1:0] RUN_MAX = '1;

  logic [W-1:0]             mem_q [DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SNK_RUN_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic                     flush_pend_q, flush_pend_d;

  logic [W-1:0]             wr_word [2];
  logic [1:0]               nwr;
  logic [PTR_W-1:0]         wr_idx0, wr_idx1;
  logic [SNK_RUN_WIDTH-1:0] run_inc;
  logic [PAY_W-1:0]         spk_pay;
  logic                     accept, vec_any, serve, pop;

  function automatic logic [W-1:0] run_word(input logic [SNK_RUN_WIDTH-1:0] c);
    return {RUN, PAY_W'(c)};
  endfunction

  // Readiness depends only on registered occupancy so two writes always fit.
  assign net_ready = arstn && (cnt_q <= CNT_W'(2));
  assign snk_valid = (cnt_q != '0);
  assign snk       = snk_valid ? mem_q[rd_ptr_q] : '0;
  assign pop       = snk_valid && snk_ready;

  // Word generation: vector transfer first, then any flush service on what remains.
  always_comb begin
    wr_word[0]   = '0;
    wr_word[1]   = '0;
    nwr          = 2'd0;
    run_cnt_d    = run_cnt_q;
    run_inc      = run_cnt_q + SNK_RUN_WIDTH'(1);
    spk_pay      = '0;
    vec_any      = 1'b0;
    accept       = net_valid && net_ready;
    serve        = (flush || flush_pend_q) && net_ready;
    flush_pend_d = (flush || flush_pend_q) && !net_ready;

    for (int unsigned i = 0; i < NET_NUM_OUT; i++) begin
      spk_pay[PAY_W-1-i] = net_out[i];
      vec_any            = vec_any | net_out[i];
    end

    if (accept) begin
      if (!vec_any) begin
        if (run_inc == RUN_MAX) begin
          wr_word[nwr[0]] = run_word(RUN_MAX);
          nwr             = nwr + 2'd1;
          run_cnt_d       = '0;
        end else begin
          run_cnt_d = run_inc;
        end
      end else begin
        if (run_cnt_q != '0) begin
          wr_word[nwr[0]] = run_word(run_cnt_q);
          nwr             = nwr + 2'd1;
        end
        wr_word[nwr[0]] = {SPK, spk_pay};
        nwr             = nwr + 2'd1;
        run_cnt_d       = '0;
      end
    end

    if (serve && (run_cnt_d != '0)) begin
      wr_word[nwr[0]] = run_word(run_cnt_d);
      nwr             = nwr + 2'd1;
      run_cnt_d       = '0;
    end

    wr_idx0  = rd_ptr_q + PTR_W'(cnt_q);
    wr_idx1  = wr_idx0 + PTR_W'(1);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(nwr) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      run_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      run_cnt_q    <= run_cnt_d;
      flush_pend_q <= flush_pend_d;
      if (nwr != 2'd0) begin
        mem_q[wr_idx0] <= wr_word[0];
      end
      if (nwr == 2'd2) begin
        mem_q[wr_idx1] <= wr_word[1];
      end
    end
  end

endmodule

// File: tb/tb_network_sink.sv
// Directed bench for network_sink with NET_NUM_OUT=4, SNK_RUN_WIDTH=3 (5-bit words).
module tb_network_sink;

  localparam int unsigned N  = 4;
  localparam int unsigned RW = 3;
  localparam int unsigned W  = 5;

  logic         clk = 1'b0;
  logic         arstn;
  logic         net_valid;
  logic         net_ready;
  logic         net_out [0:N-1];
  logic         flush;
  logic         snk_valid;
  logic         snk_ready;
  logic [W-1:0] snk;

  int n_checks = 0;
  int n_errors = 0;

  // vec[3] is net_out[0], so an SPK word is simply {1'b0, vec}
  typedef struct {
    logic       nv;
    logic [3:0] vec;
    logic       fl;
    logic       sr;
    logic [6:0] exp;  // {net_ready, snk_valid, snk} sampled before this row drives
  } row_t;

  row_t tbl[$];

  network_sink #(.SNK_RUN_WIDTH(RW)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .net_valid (net_valid),
    .net_ready (net_ready),
    .net_out   (net_out),
    .flush     (flush),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .snk       (snk)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic nv, input logic [3:0] vec, input logic fl, input logic sr);
    net_valid = nv;
    flush     = fl;
    snk_ready = sr;
    for (int i = 0; i < int'(N); i++) net_out[i] = vec[3-i];
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {net_ready, snk_valid, snk};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got net_ready=%b snk_valid=%b snk=%b, expected net_ready=%b snk_valid=%b snk=%b",
               name, act[6], act[5], act[4:0], exp[6], exp[5], exp[4:0]);
    end
  endtask

  initial begin
    // single SPK, then RUN(3)+SPK, then saturating run and flush-with-zero-vector
    tbl.push_back('{1'b1, 4'b1000, 1'b0, 1'b1, 7'b1_0_00000});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 7'b1_1_01000});
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 7'b1_0_00000});
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 7'b1_0_00000});
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 7'b1_0_00000});
    tbl.push_back('{1'b1, 4'b0100, 1'b0, 1'b1, 7'b1_0_00000});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 7'b1_1_10011});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 7'b1_1_00100});
    for (int i = 0; i < 7; i++) tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 7'b1_0_00000});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 1'b1, 7'b1_1_10111});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 7'b1_1_10001});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 7'b1_0_00000});
    // backpressure: three accepted, stall, then drain in order
    tbl.push_back('{1'b1, 4'b1100, 1'b0, 1'b0, 7'b1_0_00000});
    tbl.push_back('{1'b1, 4'b1010, 1'b0, 1'b0, 7'b1_1_01100});
    tbl.push_back('{1'b1, 4'b0011, 1'b0, 1'b0, 7'b1_1_01100});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 7'b0_1_01100});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 1'b1, 7'b0_1_01100});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 1'b1, 7'b1_1_01010});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 7'b1_1_00011});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 7'b1_1_01111});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 7'b1_0_00000});

    arstn = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    repeat (2) tick();
    check("reset", 7'b0_0_00000);
    arstn = 1'b1;
    #1;

    foreach (tbl[i]) begin
      check($sformatf("row%0d", i), tbl[i].exp);
      drive(tbl[i].nv, tbl[i].vec, tbl[i].fl, tbl[i].sr);
      tick();
    end

    // flush requested while full stays pending and is served with that cycle's zero vector
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'b1000, 1'b0, 1'b0); tick(); check("pend_run5", 7'b1_1_10101);
    drive(1'b1, 4'b0100, 1'b0, 1'b0); tick(); check("pend_full", 7'b0_1_10101);
    drive(1'b0, 4'b0000, 1'b1, 1'b0); tick(); check("pend_flush", 7'b0_1_10101);
    drive(1'b0, 4'b0000, 1'b0, 1'b1); tick(); check("pend_drain", 7'b1_1_01000);
    drive(1'b1, 4'b0000, 1'b0, 1'b1); tick(); check("pend_serve", 7'b1_1_00100);
    drive(1'b0, 4'b0000, 1'b0, 1'b1); tick(); check("pend_run1", 7'b1_1_10001);
    tick();                                   check("pend_empty", 7'b1_0_00000);
    drive(1'b1, 4'b0000, 1'b0, 1'b1); tick();
    drive(1'b0, 4'b0000, 1'b0, 1'b1); tick(); check("pend_cleared", 7'b1_0_00000);

    // run_cnt=1 here; queue RUN1+SPK, build run 5, fill to 4 with a double write, then reset
    drive(1'b1, 4'b1000, 1'b0, 1'b0); tick(); check("rst_q2", 7'b1_1_10001);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 1'b0, 1'b0);
      tick();
    end
    check("rst_run5", 7'b1_1_10001);
    drive(1'b1, 4'b0001, 1'b0, 1'b0); tick(); check("rst_full4", 7'b0_1_10001);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    arstn = 1'b0;
    #1;
    check("rst_async", 7'b0_0_00000);
    tick();
    check("rst_hold", 7'b0_0_00000);
    arstn = 1'b1;
    #1;
    check("rst_release", 7'b1_0_00000);
    drive(1'b1, 4'b0010, 1'b0, 1'b1); tick(); check("rst_spk_only", 7'b1_1_00010);
    drive(1'b0, 4'b0000, 1'b1, 1'b1); tick(); check("rst_drained", 7'b1_0_00000);
    drive(1'b0, 4'b0000, 1'b0, 1'b1); tick(); check("rst_no_run", 7'b1_0_00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
